// File: rtl/reg_file_pkg.sv
// Shared encodings and helpers for the register file and its pointer-pair ALU.
package reg_file_pkg;

  localparam logic [1:0] PTR_NONE = 2'b00;
  localparam logic [1:0] PTR_INC  = 2'b01;
  localparam logic [1:0] PTR_DEC  = 2'b10;
  localparam logic [1:0] PTR_ADD  = 2'b11;

  // High-byte register of the pair whose low register is sel.
  function automatic int pair_hi_idx(input int sel);
    return sel | 1;
  endfunction

endpackage

// File: rtl/reg_file_pair_pair_alu.sv
// Combinational 2*DATA_W pointer adder: next pointer value and wrap (carry/borrow) bit.
module pair_alu
  import reg_file_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [2*DATA_W-1:0]      p,
  input  logic [1:0]               op,
  input  logic signed [DATA_W-1:0] off,
  output logic [2*DATA_W-1:0]      p_next,
  output logic                     wrap
);

  localparam int PW = 2 * DATA_W;

  logic [PW-1:0] operand;
  logic          neg;
  logic [PW:0]   sum;

  always_comb begin
    operand = '0;
    neg     = 1'b0;
    case (op)
      PTR_INC: operand = PW'(1);
      PTR_DEC: begin
        operand = '1;
        neg     = 1'b1;
      end
      PTR_ADD: begin
        operand = {{DATA_W{off[DATA_W-1]}}, off};
        neg     = off[DATA_W-1];
      end
      default: begin
        operand = '0;
        neg     = 1'b0;
      end
    endcase
  end

  // Adding a negative operand wraps exactly when the modular add produces no carry.
  assign sum    = {1'b0, p} + {1'b0, operand};
  assign p_next = sum[PW-1:0];
  assign wrap   = (op != PTR_NONE) & (sum[PW] ^ neg);

endmodule

// File: rtl/reg_file_pair.sv
// General-purpose register file: one write port, two combinational read ports,
// and even/odd register pairs usable as 2*DATA_W-bit pointers.
module reg_file_pair
  import reg_file_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 16,
  parameter int SEL_W  = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [SEL_W-1:0]         wr_sel,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [SEL_W-1:0]         rd_a_sel,
  output logic [DATA_W-1:0]        rd_a,
  input  logic [SEL_W-1:0]         ptr_sel,
  input  logic [1:0]               ptr_op,
  input  logic signed [DATA_W-1:0] ptr_off,
  output logic [DATA_W-1:0]        rd_b,
  output logic [DATA_W-1:0]        ptr_hi,
  output logic                     ptr_wrap
);

  localparam int PW = 2 * DATA_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              ptr_wrap_q;
  logic              ptr_wrap_d;

  logic [SEL_W-1:0]  hi_sel;
  logic              ptr_even;
  logic              collide;
  logic              upd;
  logic [PW-1:0]     pair_p;
  logic [PW-1:0]     pair_next;
  logic              pair_wrap;

  assign hi_sel   = SEL_W'(pair_hi_idx(int'(ptr_sel)));
  assign ptr_even = ~ptr_sel[0];
  assign pair_p   = {regs_q[hi_sel], regs_q[ptr_sel]};

  // A write touching either half of the pair wins; the whole update is dropped.
  assign collide = wr_en & ((wr_sel == ptr_sel) | (wr_sel == hi_sel));
  assign upd     = ptr_even & (ptr_op != PTR_NONE) & ~collide;

  pair_alu #(
    .DATA_W (DATA_W)
  ) u_pair_alu (
    .p      (pair_p),
    .op     (ptr_op),
    .off    (ptr_off),
    .p_next (pair_next),
    .wrap   (pair_wrap)
  );

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[wr_sel] = wr_data;
    end
    if (upd) begin
      regs_d[ptr_sel] = pair_next[DATA_W-1:0];
      regs_d[hi_sel]  = pair_next[PW-1:DATA_W];
    end
    ptr_wrap_d = upd & pair_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      ptr_wrap_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      ptr_wrap_q <= ptr_wrap_d;
    end
  end

  assign rd_a     = regs_q[rd_a_sel];
  assign rd_b     = regs_q[ptr_sel];
  assign ptr_hi   = ptr_even ? regs_q[hi_sel] : '0;
  assign ptr_wrap = ptr_wrap_q;

endmodule

// File: tb/tb_reg_file_pair.sv
// Self-checking bench for reg_file_pair against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_reg_file_pair;

  localparam int DATA_W = 8;
  localparam int NREGS  = 16;
  localparam int SEL_W  = 4;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b1;
  logic              wr_en    = 1'b0;
  logic [SEL_W-1:0]  wr_sel   = '0;
  logic [DATA_W-1:0] wr_data  = '0;
  logic [SEL_W-1:0]  rd_a_sel = '0;
  logic [SEL_W-1:0]  ptr_sel  = '0;
  logic [1:0]        ptr_op   = '0;
  logic [DATA_W-1:0] ptr_off  = '0;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] ptr_hi;
  logic              ptr_wrap;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] m_reg [NREGS];
  logic              m_wrap;

  reg_file_pair #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .SEL_W  (SEL_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .rd_a_sel (rd_a_sel),
    .rd_a     (rd_a),
    .ptr_sel  (ptr_sel),
    .ptr_op   (ptr_op),
    .ptr_off  (ptr_off),
    .rd_b     (rd_b),
    .ptr_hi   (ptr_hi),
    .ptr_wrap (ptr_wrap)
  );

  always #5 clk = ~clk;

  // One clock edge with the currently driven inputs; the model follows the rules
  // as plain 16-bit integer arithmetic. Leaves write/pointer strobes idle.
  task automatic cycle();
    int  hi;
    int  p;
    int  np;
    int  delta;
    bit  coll;
    bit  upd;
    hi    = int'(ptr_sel) | 1;
    coll  = wr_en && ((int'(wr_sel) == int'(ptr_sel)) || (int'(wr_sel) == hi));
    upd   = (ptr_sel[0] == 1'b0) && (ptr_op != 2'b00) && !coll;
    p     = int'(m_reg[hi]) * 256 + int'(m_reg[ptr_sel]);
    case (ptr_op)
      2'b01:   delta = 1;
      2'b10:   delta = -1;
      2'b11:   delta = int'($signed(ptr_off));
      default: delta = 0;
    endcase
    np = p + delta;
    @(posedge clk);
    #1;
    if (wr_en) m_reg[wr_sel] = wr_data;
    m_wrap = 1'b0;
    if (upd) begin
      m_wrap = (np < 0) || (np > 65535);
      np     = np & 32'hFFFF;
      m_reg[ptr_sel] = np[7:0];
      m_reg[hi]      = np[15:8];
    end
    wr_en  = 1'b0;
    ptr_op = 2'b00;
  endtask

  task automatic write_reg(input int sel, input int data);
    wr_en   = 1'b1;
    wr_sel  = SEL_W'(sel);
    wr_data = DATA_W'(data);
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #7;
    for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
    m_wrap = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      rd_a_sel = SEL_W'(i);
      #1;
      n_tests++;
      if (rd_a !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h want 00", i, rd_a);
      end
    end
    n_tests++;
    if (ptr_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wrap: got %b want 0", ptr_wrap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    rd_a_sel = 4'd3;
    write_reg(3, 8'hA5);
    n_tests++;
    if (rd_a !== 8'hA5) begin
      n_fail++;
      $display("FAIL write_r3: got %h want a5", rd_a);
    end
  endtask

  task automatic test_inc();
    write_reg(4, 8'hFF);
    write_reg(5, 8'h00);
    ptr_sel = 4'd4;
    ptr_op  = 2'b01;
    cycle();
    n_tests++;
    if ({ptr_hi, rd_b} !== 16'h0100 || ptr_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL inc_carry_byte: got %h wrap %b want 0100 wrap 0", {ptr_hi, rd_b}, ptr_wrap);
    end
    write_reg(4, 8'hFF);
    write_reg(5, 8'hFF);
    ptr_op = 2'b01;
    cycle();
    n_tests++;
    if ({ptr_hi, rd_b} !== 16'h0000 || ptr_wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL inc_wrap: got %h wrap %b want 0000 wrap 1", {ptr_hi, rd_b}, ptr_wrap);
    end
    cycle();
    n_tests++;
    if (ptr_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL inc_wrap_pulse: got %b want 0", ptr_wrap);
    end
  endtask

  task automatic test_dec_add();
    write_reg(6, 8'h00);
    write_reg(7, 8'h00);
    ptr_sel = 4'd6;
    ptr_op  = 2'b10;
    cycle();
    n_tests++;
    if ({ptr_hi, rd_b} !== 16'hFFFF || ptr_wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL dec_wrap: got %h wrap %b want ffff wrap 1", {ptr_hi, rd_b}, ptr_wrap);
    end
    ptr_op  = 2'b11;
    ptr_off = 8'hFE;
    cycle();
    n_tests++;
    if ({ptr_hi, rd_b} !== 16'hFFFD || ptr_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL add_neg: got %h wrap %b want fffd wrap 0", {ptr_hi, rd_b}, ptr_wrap);
    end
    ptr_op  = 2'b11;
    ptr_off = 8'h05;
    cycle();
    n_tests++;
    if ({ptr_hi, rd_b} !== 16'h0002 || ptr_wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL add_pos_wrap: got %h wrap %b want 0002 wrap 1", {ptr_hi, rd_b}, ptr_wrap);
    end
  endtask

  task automatic test_collision();
    write_reg(8, 8'h10);
    write_reg(9, 8'h00);
    ptr_sel = 4'd8;
    ptr_op  = 2'b01;
    wr_en   = 1'b1;
    wr_sel  = 4'd9;
    wr_data = 8'h55;
    cycle();
    n_tests++;
    if (ptr_hi !== 8'h55 || rd_b !== 8'h10 || ptr_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_hi: got hi %h lo %h wrap %b want 55 10 0", ptr_hi, rd_b, ptr_wrap);
    end
    ptr_op   = 2'b01;
    wr_en    = 1'b1;
    wr_sel   = 4'd2;
    wr_data  = 8'h3C;
    rd_a_sel = 4'd2;
    cycle();
    n_tests++;
    if (rd_a !== 8'h3C || {ptr_hi, rd_b} !== 16'h5511) begin
      n_fail++;
      $display("FAIL disjoint_wr_ptr: got r2 %h pair %h want 3c 5511", rd_a, {ptr_hi, rd_b});
    end
  endtask

  task automatic test_odd();
    write_reg(5, 8'h7E);
    ptr_sel = 4'd5;
    ptr_op  = 2'b01;
    cycle();
    n_tests++;
    if (rd_b !== 8'h7E || ptr_hi !== 8'h00 || ptr_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL odd_sel: got rd_b %h hi %h wrap %b want 7e 00 0", rd_b, ptr_hi, ptr_wrap);
    end
    for (int i = 0; i < NREGS; i++) begin
      rd_a_sel = SEL_W'(i);
      #0.2;
      n_tests++;
      if (rd_a !== m_reg[i]) begin
        n_fail++;
        $display("FAIL odd_unchanged_r%0d: got %h want %h", i, rd_a, m_reg[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_sel   = SEL_W'($urandom_range(0, NREGS - 1));
      wr_data  = DATA_W'($urandom);
      ptr_sel  = SEL_W'($urandom_range(0, NREGS - 1));
      ptr_op   = 2'($urandom);
      ptr_off  = DATA_W'($urandom);
      rd_a_sel = SEL_W'($urandom_range(0, NREGS - 1));
      cycle();
      n_tests++;
      if (rd_a !== m_reg[rd_a_sel] || rd_b !== m_reg[ptr_sel] || ptr_wrap !== m_wrap ||
          ptr_hi !== (ptr_sel[0] ? 8'h00 : m_reg[ptr_sel | 4'd1])) begin
        n_fail++;
        $display("FAIL random_%0d: got a %h b %h hi %h wrap %b want a %h b %h wrap %b",
                 n, rd_a, rd_b, ptr_hi, ptr_wrap, m_reg[rd_a_sel], m_reg[ptr_sel], m_wrap);
      end
    end
  endtask

  task automatic test_back_to_back();
    write_reg(10, 8'hFD);
    write_reg(11, 8'h12);
    ptr_sel = 4'd10;
    for (int n = 0; n < 5; n++) begin
      ptr_op = 2'b01;
      cycle();
    end
    n_tests++;
    if ({ptr_hi, rd_b} !== 16'h1302) begin
      n_fail++;
      $display("FAIL stream_inc: got %h want 1302", {ptr_hi, rd_b});
    end
  endtask

  task automatic test_async_reset();
    ptr_sel = 4'd0;
    for (int n = 0; n < 3; n++) begin
      ptr_op = 2'b01;
      cycle();
    end
    ptr_op = 2'b01;
    #2;
    rst_n = 1'b0;
    #0.5;
    for (int i = 0; i < NREGS; i++) begin
      rd_a_sel = SEL_W'(i);
      #0.2;
      n_tests++;
      if (rd_a !== 8'h00) begin
        n_fail++;
        $display("FAIL async_reset_r%0d: got %h want 00", i, rd_a);
      end
    end
    ptr_op = 2'b00;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
    m_wrap = 1'b0;
    ptr_op = 2'b01;
    cycle();
    n_tests++;
    if ({ptr_hi, rd_b} !== 16'h0001 || ptr_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_inc: got %h wrap %b want 0001 wrap 0", {ptr_hi, rd_b}, ptr_wrap);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_write();
    test_inc();
    test_dec_add();
    test_collision();
    test_odd();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
